// File: rtl/code_player.sv
// code_player: replays a stored four-lane code as timed lamp pulses.
//   clk    - system clock, rising edge
//   reset  - asynchronous active-high reset
//   lane1..lane4 [MAX_LEN] - code vectors, bit i = position i
//   len [4]  - positions to play (clamped to MAX_LEN)
//   start    - begin playback (ignored unless idle)
//   abort    - stop playback next cycle, no done pulse
//   L1..L4   - lamp outputs
//   busy     - playback in progress
//   done     - one-cycle completion pulse
//   pos [3]  - position currently playing
//   error    - sticky: a played column was not one-hot
// Optional: define CODE_PLAYER_LOOP_EN for continuous repeated playback.
module code_player #(
    parameter int MAX_LEN    = 7,
    parameter int ON_CYCLES  = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [MAX_LEN-1:0] lane1,
    input  logic [MAX_LEN-1:0] lane2,
    input  logic [MAX_LEN-1:0] lane3,
    input  logic [MAX_LEN-1:0] lane4,
    input  logic [3:0]         len,
    input  logic               start,
    input  logic               abort,
    output logic               L1,
    output logic               L2,
    output logic               L3,
    output logic               L4,
    output logic               busy,
    output logic               done,
    output logic [2:0]         pos,
    output logic               error
);
    localparam int MAXC = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [1:0] {IDLE, ON, GAP, DONE} state_t;

    state_t             state, state_n;
    logic [CW-1:0]      cnt;
    logic [MAX_LEN-1:0] s1, s2, s3, s4;
    logic [3:0]         slen, len_c;
    logic [2:0]         pos_n;
    logic               on_end, gap_end, last, go, adv, wrap;
    logic [3:0]         col_in, col_next, col_zero;

    assign len_c    = (len > 4'(MAX_LEN)) ? 4'(MAX_LEN) : len;
    assign on_end   = cnt == CW'(ON_CYCLES - 1);
    assign gap_end  = cnt == CW'(GAP_CYCLES - 1);
    assign last     = ({1'b0, pos} + 4'd1) >= slen;
    assign pos_n    = pos + 3'd1;
    assign go       = state == IDLE && start && !abort;
    assign adv      = state == GAP && gap_end && !abort;
    assign col_in   = {lane1[0], lane2[0], lane3[0], lane4[0]};
    assign col_next = {s1[pos_n], s2[pos_n], s3[pos_n], s4[pos_n]};
    assign col_zero = {s1[0], s2[0], s3[0], s4[0]};

    function automatic logic bad(input logic [3:0] c);
        return $countones(c) != 1;
    endfunction

`ifdef CODE_PLAYER_LOOP_EN
    localparam logic LOOP = 1'b1;
    logic wrap_q;
    // Wrapping back to position 0 raises done while ON restarts.
    always_ff @(posedge clk or posedge reset)
        if (reset) wrap_q <= 1'b0;
        else       wrap_q <= adv && last;
    assign wrap = wrap_q;
`else
    localparam logic LOOP = 1'b0;
    assign wrap = 1'b0;
`endif

    always_comb begin
        state_n = state;
        case (state)
            IDLE: state_n = go ? (len_c == 4'd0 ? DONE : ON) : IDLE;
            ON:   state_n = abort ? IDLE : (on_end ? GAP : ON);
            GAP:  state_n = abort ? IDLE : (!gap_end ? GAP : (!last || LOOP) ? ON : DONE);
            DONE: state_n = (LOOP && !abort) ? DONE : IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            pos   <= '0;
            s1    <= '0;
            s2    <= '0;
            s3    <= '0;
            s4    <= '0;
            slen  <= '0;
            error <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= (state_n == state && (state == ON || state == GAP)) ? cnt + CW'(1) : '0;
            if (go) begin
                s1    <= lane1;
                s2    <= lane2;
                s3    <= lane3;
                s4    <= lane4;
                slen  <= len_c;
                pos   <= '0;
                error <= len_c != 4'd0 && bad(col_in);
            end else if (adv && !last) begin
                pos   <= pos_n;
                error <= error | bad(col_next);
            end else if (adv && LOOP) begin
                pos   <= '0;
                error <= error | bad(col_zero);
            end
        end

    assign L1   = state == ON && s1[pos];
    assign L2   = state == ON && s2[pos];
    assign L3   = state == ON && s3[pos];
    assign L4   = state == ON && s4[pos];
    assign busy = state == ON || state == GAP;
    assign done = state == DONE || wrap;
endmodule

// File: doc/code_player.md
Name: code_player

Overview:
- Playback side of the four-button code-entry interface.
- Takes a stored code and replays it as timed lamp pulses on four lanes, L1..L4.
- Each position's one-hot lane column drives the lamps in the same lane/position encoding the button-capture logic produces (lane k, position i).
- Used for "show secret" and hint display in the guessing game; sits between the captured-code registers and the LED drivers.

Parameters:
- MAX_LEN, 7, maximum number of code positions; width of each lane vector.
- ON_CYCLES, 4, clock cycles a lamp is lit per position; legal range >=1.
- GAP_CYCLES, 2, clock cycles all lamps are dark after each position; legal range >=1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  reset, asynchronous, active-high.
- lane1  input  MAX_LEN  lane-1 code vector; bit i = position i.
- lane2  input  MAX_LEN  lane-2 code vector.
- lane3  input  MAX_LEN  lane-3 code vector.
- lane4  input  MAX_LEN  lane-4 code vector.
- len  input  4  number of positions to play.
- start  input  1  single-cycle request to begin playback.
- abort  input  1  stops playback immediately.
- L1  output  1  lane-1 lamp.
- L2  output  1  lane-2 lamp.
- L3  output  1  lane-3 lamp.
- L4  output  1  lane-4 lamp.
- busy  output  1  playback in progress.
- done  output  1  one-cycle pulse when playback completes.
- pos  output  3  index of the position currently playing.
- error  output  1  sticky flag: a played column was not one-hot.

Behaviour:
- Reset (any time, including mid-playback): state IDLE; L1..L4, busy, done, error = 0; pos = 0; snapshot registers cleared.
- States: IDLE, ON, GAP, DONE.
- IDLE + start sampled at edge N:
  - Snapshot lane1..lane4 and len. len > MAX_LEN is clamped to MAX_LEN.
  - error cleared; pos = 0.
  - If clamped len == 0: go to DONE (done high in cycle N+1; busy and lamps never assert).
  - Otherwise go to ON at N+1.
- ON: Lk = snapshot lanek[pos] for k = 1..4; busy = 1; lasts exactly ON_CYCLES cycles, then GAP.
- error: set on entering ON if the column {lane1..lane4}[pos] has popcount != 1.
  - Zero lanes: dark slot, timing preserved.
  - Multiple lanes: all set lanes lit.
- GAP: all lamps 0; busy = 1; lasts GAP_CYCLES cycles.
  - Then pos+1 < len: pos increments, go to ON.
  - Otherwise go to DONE.
- DONE: done = 1 for exactly one cycle; busy = 0; lamps 0; then IDLE. pos holds its last value until the next start.
- Total timing: from the start edge, done rises 1 + len*(ON_CYCLES+GAP_CYCLES) cycles later. busy spans cycles 1 .. len*(ON_CYCLES+GAP_CYCLES).
- Lane inputs are don't-care after the snapshot; changes during playback have no effect.
- start while busy or in DONE: ignored.
- abort (synchronous, any non-IDLE state):
  - Next cycle: IDLE, lamps 0, busy 0, no done pulse. error keeps its value.
  - abort and start together in IDLE: abort wins, start ignored.
- Counter widths: cycle counter sized for max(ON_CYCLES, GAP_CYCLES). Counters never wrap; each compare is exact at the terminal count.

Optional Feature:
- Macro: CODE_PLAYER_LOOP_EN.
- Defined:
  - Playback repeats continuously.
  - After the last GAP, done pulses for one cycle while the block re-enters ON at pos 0 in the same cycle; busy stays 1.
  - The snapshot is reused.
  - Only abort or reset stops the loop.
  - len == 0 pulses done every cycle until abort.
- Undefined: single playback as above; no loop logic synthesized.

Test Plan:
(ON_CYCLES=4, GAP_CYCLES=2 unless noted; cycle 0 = start edge.)
1. Reset asserted mid-ON with L2 lit -> L1..L4, busy, done, error, pos all 0 immediately (asynchronous); after release, block idles and accepts start.
2. lane1=7'b0000001, lane2=7'b0000010, lane3=7'b0000100, lane4=7'b0001000, len=4, start -> lamp sequence:
   - L1 high cycles 1-4, L2 7-10, L3 13-16, L4 19-22.
   - All lamps dark on cycles 5-6, 11-12, 17-18, 23-24.
   - busy cycles 1-24; done only at cycle 25; pos 0,1,2,3; error 0.
3. len=0, start -> done at cycle 1; busy and lamps never assert.
4. len=9, every column one-hot on L3 -> clamped to 7; L3 pulses 7 times; done at cycle 43.
5. Abort at cycle 8 of scenario 2 -> L2 low and busy low at cycle 9; no done pulse; a new start at cycle 12 replays from pos 0.
6. Position 2 has lane1 and lane3 both set -> L1 and L3 lit together on cycles 13-16; error rises at cycle 13 and stays 1 until the next start clears it.
